// File: rtl/decode_pipe.sv
// Decode stage: register file with write-first bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_D,
  input  logic [31:0]           instr_D,
  input  logic [DATA_WIDTH-1:0] pc_D,
  input  logic [CTRL_WIDTH-1:0] ctrl_D,
  input  logic [2:0]            ImmSrc_D,
  input  logic                  load_D,
  input  logic                  uses_rs2_D,
  input  logic                  flush_E,
  input  logic                  RegWrite_W,
  input  logic [ADDR_WIDTH-1:0] rd_W,
  input  logic [DATA_WIDTH-1:0] result_W,
  output logic                  stall_D,
  output logic                  valid_E,
  output logic [CTRL_WIDTH-1:0] ctrl_E,
  output logic [DATA_WIDTH-1:0] rd1_E,
  output logic [DATA_WIDTH-1:0] rd2_E,
  output logic [DATA_WIDTH-1:0] ImmExt_E,
  output logic [DATA_WIDTH-1:0] pc_E,
  output logic [ADDR_WIDTH-1:0] rs1_E,
  output logic [ADDR_WIDTH-1:0] rs2_E,
  output logic [ADDR_WIDTH-1:0] rd_E,
  output logic [DATA_WIDTH-1:0] a0
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  function automatic logic [31:0] imm32(input logic [31:0] i, input logic [2:0] src);
    logic [31:0] v;
    case (src)
      3'd0:    v = {{20{i[31]}}, i[31:20]};
      3'd1:    v = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    v = {i[31:12], 12'h000};
      3'd4:    v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  logic [DATA_WIDTH-1:0] regs_r [NREGS];
  logic [ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
  logic [DATA_WIDTH-1:0] rd1_s, rd2_s, imm_s;
  logic                  we_s;
  logic                  load_e_r;
  logic                  unused_ok_s;

  assign rs1_s = ADDR_WIDTH'(instr_D[19:15]);
  assign rs2_s = ADDR_WIDTH'(instr_D[24:20]);
  assign rd_s  = ADDR_WIDTH'(instr_D[11:7]);
  assign imm_s = DATA_WIDTH'($signed(imm32(instr_D, ImmSrc_D)));
  assign we_s  = RegWrite_W && (rd_W != '0);
  assign unused_ok_s = &{1'b0, instr_D[6:0]};

  // Operand reads: x0 is hardwired, a same-cycle writeback wins over the array.
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    if (rs1_s == '0) begin
      rd1_s = '0;
    end else if (we_s && (rd_W == rs1_s)) begin
      rd1_s = result_W;
    end else begin
      rd1_s = regs_r[rs1_s];
    end
    if (rs2_s == '0) begin
      rd2_s = '0;
    end else if (we_s && (rd_W == rs2_s)) begin
      rd2_s = result_W;
    end else begin
      rd2_s = regs_r[rs2_s];
    end
  end

  // Load-use hazard: the load in EX has not produced its data yet.
  always_comb begin
    stall_D = 1'b0;
    if (valid_D && valid_E && load_e_r && (rd_E != '0)) begin
      stall_D = (rs1_s == rd_E) || (uses_rs2_D && (rs2_s == rd_E));
    end else begin
      stall_D = 1'b0;
    end
  end

  // Register file storage; writes are independent of stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs_r[k] <= '0;
    end else if (we_s) begin
      regs_r[rd_W] <= result_W;
    end
  end

  generate
    if (NREGS > 10) begin : g_a0
      assign a0 = regs_r[ADDR_WIDTH'(10)];
    end else begin : g_no_a0
      assign a0 = '0;
    end
  endgenerate

  // ID/EX register; a bubble only kills the control-relevant fields and holds the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_E  <= 1'b0;
      load_e_r <= 1'b0;
      ctrl_E   <= '0;
      rd1_E    <= '0;
      rd2_E    <= '0;
      ImmExt_E <= '0;
      pc_E     <= '0;
      rs1_E    <= '0;
      rs2_E    <= '0;
      rd_E     <= '0;
    end else if (flush_E || stall_D) begin
      valid_E  <= 1'b0;
      load_e_r <= 1'b0;
      ctrl_E   <= '0;
      rd_E     <= '0;
    end else begin
      valid_E  <= valid_D;
      load_e_r <= valid_D && load_D;
      ctrl_E   <= valid_D ? ctrl_D : '0;
      rd1_E    <= rd1_s;
      rd2_E    <= rd2_s;
      ImmExt_E <= imm_s;
      pc_E     <= pc_D;
      rs1_E    <= rs1_s;
      rs2_E    <= rs2_s;
      rd_E     <= rd_s;
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: immediate table, directed hazard/reset
// sequences and randomized traffic against an array-based reference model.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst, valid_D, load_D, uses_rs2_D, flush_E, RegWrite_W;
  logic [31:0] instr_D, pc_D, result_W;
  logic [11:0] ctrl_D;
  logic [2:0]  ImmSrc_D;
  logic [4:0]  rd_W;
  logic        stall_D, valid_E;
  logic [11:0] ctrl_E;
  logic [31:0] rd1_E, rd2_E, ImmExt_E, pc_E, a0;
  logic [4:0]  rs1_E, rs2_E, rd_E;

  decode_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CTRL_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
    .ctrl_D(ctrl_D), .ImmSrc_D(ImmSrc_D), .load_D(load_D), .uses_rs2_D(uses_rs2_D),
    .flush_E(flush_E), .RegWrite_W(RegWrite_W), .rd_W(rd_W), .result_W(result_W),
    .stall_D(stall_D), .valid_E(valid_E), .ctrl_E(ctrl_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
    .ImmExt_E(ImmExt_E), .pc_E(pc_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .a0(a0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic last_stall;

  // reference model state
  logic [31:0] mreg [32];
  logic        mvalid, mload;
  logic [11:0] mctrl;
  logic [31:0] mrd1, mrd2, mimm, mpc;
  logic [4:0]  mrs1, mrs2, mrd;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rd;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // immediate value computed arithmetically from the field weights
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] src);
    logic [31:0] s;
    s = i[31] ? 32'hFFFF_FFFF : 32'd0;
    case (src)
      3'd0: return s * 32'd2048 + 32'(i[30:20]);
      3'd1: return s * 32'd2048 + 32'(i[30:25]) * 32'd32 + 32'(i[11:7]);
      3'd2: return s * 32'd4096 + 32'(i[7]) * 32'd2048 + 32'(i[30:25]) * 32'd32 + 32'(i[11:8]) * 32'd2;
      3'd3: return 32'(i[31:12]) * 32'd4096;
      3'd4: return s * 32'd1048576 + 32'(i[19:12]) * 32'd4096 + 32'(i[20]) * 32'd2048 + 32'(i[30:21]) * 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWrite_W && rd_W == a) return result_W;
    return mreg[a];
  endfunction

  task automatic model_reset();
    foreach (mreg[k]) mreg[k] = 32'd0;
    mvalid = 1'b0; mload = 1'b0; mctrl = 12'd0;
    mrd1 = 32'd0; mrd2 = 32'd0; mimm = 32'd0; mpc = 32'd0;
    mrs1 = 5'd0; mrs2 = 5'd0; mrd = 5'd0;
  endtask

  task automatic idle();
    rst = 1'b0; valid_D = 1'b0; instr_D = 32'd0; pc_D = 32'd0; ctrl_D = 12'd0;
    ImmSrc_D = 3'd0; load_D = 1'b0; uses_rs2_D = 1'b0; flush_E = 1'b0;
    RegWrite_W = 1'b0; rd_W = 5'd0; result_W = 32'd0;
  endtask

  // one clock: check stall mid-cycle, advance the model, check registered outputs
  task automatic cycle(input string tag);
    logic es;
    logic [4:0] r1, r2, rd;
    logic [31:0] v1, v2;
    r1 = instr_D[19:15]; r2 = instr_D[24:20]; rd = instr_D[11:7];
    #4;
    es = valid_D && mvalid && mload && (mrd != 5'd0) &&
         ((r1 == mrd) || (uses_rs2_D && (r2 == mrd)));
    last_stall = stall_D;
    chk({tag, ":stall_D"}, 32'(stall_D), 32'(es));
    v1 = ref_read(r1);
    v2 = ref_read(r2);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (RegWrite_W && rd_W != 5'd0) mreg[rd_W] = result_W;
      if (flush_E || es) begin
        mvalid = 1'b0; mload = 1'b0; mctrl = 12'd0; mrd = 5'd0;
      end else begin
        mvalid = valid_D; mload = valid_D && load_D; mctrl = valid_D ? ctrl_D : 12'd0;
        mrd1 = v1; mrd2 = v2; mimm = ref_imm(instr_D, ImmSrc_D); mpc = pc_D;
        mrs1 = r1; mrs2 = r2; mrd = rd;
      end
    end
    chk({tag, ":valid_E"}, 32'(valid_E), 32'(mvalid));
    chk({tag, ":ctrl_E"}, 32'(ctrl_E), 32'(mctrl));
    chk({tag, ":a0"}, a0, mreg[10]);
    if (mvalid) begin
      chk({tag, ":rd1_E"}, rd1_E, mrd1);
      chk({tag, ":rd2_E"}, rd2_E, mrd2);
      chk({tag, ":ImmExt_E"}, ImmExt_E, mimm);
      chk({tag, ":pc_E"}, pc_E, mpc);
      chk({tag, ":rs1_E"}, 32'(rs1_E), 32'(mrs1));
      chk({tag, ":rs2_E"}, 32'(rs2_E), 32'(mrs2));
      chk({tag, ":rd_E"}, 32'(rd_E), 32'(mrd));
    end
  endtask

  task automatic decode(input logic [31:0] ins, input logic [2:0] src, input logic ld, input logic u2);
    valid_D = 1'b1; instr_D = ins; ImmSrc_D = src; load_D = ld; uses_rs2_D = u2;
    ctrl_D = 12'($urandom); pc_D = $urandom;
  endtask

  initial begin
    vecs[0] = '{32'h0032_8313, 3'd0, 32'h0000_0003, 5'd6};
    vecs[1] = '{32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF, 5'd1};
    vecs[2] = '{32'hFE00_0E23, 3'd1, 32'hFFFF_FFFC, 5'd28};
    vecs[3] = '{32'hFE00_0EE3, 3'd2, 32'hFFFF_FFFC, 5'd29};
    vecs[4] = '{32'h1234_5037, 3'd3, 32'h1234_5000, 5'd0};
    vecs[5] = '{32'hFF9F_F06F, 3'd4, 32'hFFFF_FFF8, 5'd0};
    vecs[6] = '{32'h0080_00EF, 3'd4, 32'h0000_0008, 5'd1};
    vecs[7] = '{32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 5'd31};
    vecs[8] = '{32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 5'd31};
    vecs[9] = '{32'h8000_0000, 3'd7, 32'h0000_0000, 5'd0};

    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    #4;
    chk("reset:valid_E", 32'(valid_E), 32'd0);
    chk("reset:ctrl_E", 32'(ctrl_E), 32'd0);
    chk("reset:rd_E", 32'(rd_E), 32'd0);
    chk("reset:a0", a0, 32'd0);
    chk("reset:stall_D", 32'(stall_D), 32'd0);
    @(posedge clk); #1;

    // immediate table
    for (int i = 0; i < 10; i++) begin
      decode(vecs[i].instr, vecs[i].src, 1'b0, 1'b0);
      cycle("tbl");
      chk("tbl:imm", ImmExt_E, vecs[i].exp_imm);
      chk("tbl:rd", 32'(rd_E), 32'(vecs[i].exp_rd));
    end

    // write x5 then addi x6,x5,3
    idle(); RegWrite_W = 1'b1; rd_W = 5'd5; result_W = 32'h0000_00AA;
    cycle("wr_x5");
    idle(); decode(32'h0032_8313, 3'd0, 1'b0, 1'b0);
    cycle("addi");
    chk("addi:rd1", rd1_E, 32'h0000_00AA);
    chk("addi:imm", ImmExt_E, 32'h0000_0003);
    chk("addi:valid", 32'(valid_E), 32'd1);

    // same-cycle bypass for add x8,x7,x7
    idle(); decode(32'h0073_8433, 3'd0, 1'b0, 1'b1);
    RegWrite_W = 1'b1; rd_W = 5'd7; result_W = 32'h0000_1234;
    cycle("bypass");
    chk("bypass:rd1", rd1_E, 32'h0000_1234);
    chk("bypass:rd2", rd2_E, 32'h0000_1234);

    // lw x9 followed by dependent add x10,x9,x1
    idle(); decode(32'h0000_A483, 3'd0, 1'b1, 1'b0);
    cycle("lw");
    idle(); decode(32'h0014_8533, 3'd0, 1'b0, 1'b1);
    cycle("hazard");
    chk("hazard:stall", 32'(last_stall), 32'd1);
    chk("hazard:bubble", 32'(valid_E), 32'd0);
    cycle("resume");
    chk("resume:stall", 32'(last_stall), 32'd0);
    chk("resume:valid", 32'(valid_E), 32'd1);
    chk("resume:rd", 32'(rd_E), 32'd10);

    // write to x0 discarded; B-type immediate
    idle(); RegWrite_W = 1'b1; rd_W = 5'd0; result_W = 32'hFFFF_FFFF;
    cycle("wr_x0");
    idle(); decode(32'hFE00_0EE3, 3'd2, 1'b0, 1'b1);
    RegWrite_W = 1'b1; rd_W = 5'd0; result_W = 32'hFFFF_FFFF;
    cycle("x0");
    chk("x0:rd1", rd1_E, 32'd0);
    chk("x0:immB", ImmExt_E, 32'hFFFF_FFFC);

    // flush and stall together, with a write to a0
    idle(); decode(32'h0000_A483, 3'd0, 1'b1, 1'b0);
    cycle("lw2");
    idle(); decode(32'h0014_8533, 3'd0, 1'b0, 1'b1);
    flush_E = 1'b1; RegWrite_W = 1'b1; rd_W = 5'd10; result_W = 32'h0000_0055;
    cycle("flush");
    chk("flush:stall", 32'(last_stall), 32'd1);
    chk("flush:valid", 32'(valid_E), 32'd0);
    chk("flush:ctrl", 32'(ctrl_E), 32'd0);
    chk("flush:a0", a0, 32'h0000_0055);

    // reset with a load in EX drops the stall; writeback in that cycle is lost
    idle(); decode(32'h0000_A483, 3'd0, 1'b1, 1'b0);
    cycle("lw3");
    idle(); decode(32'h0014_8533, 3'd0, 1'b0, 1'b1);
    rst = 1'b1; RegWrite_W = 1'b1; rd_W = 5'd10; result_W = 32'h0000_0077;
    cycle("rst");
    chk("rst:valid", 32'(valid_E), 32'd0);
    chk("rst:a0", a0, 32'd0);
    rst = 1'b0; RegWrite_W = 1'b0;
    cycle("post_rst");
    chk("post_rst:stall", 32'(last_stall), 32'd0);

    // randomized traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      ins[11:7]  = 5'($urandom_range(0, 3));
      idle();
      valid_D = ($urandom_range(0, 9) < 8);
      instr_D = ins;
      ImmSrc_D = 3'($urandom_range(0, 7));
      load_D = 1'($urandom);
      uses_rs2_D = 1'($urandom);
      ctrl_D = 12'($urandom);
      pc_D = $urandom;
      flush_E = ($urandom_range(0, 9) == 0);
      RegWrite_W = 1'($urandom);
      rd_W = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 3));
      result_W = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, datapath width; ADDR_WIDTH, default 5, register address width (2^ADDR_WIDTH registers); CTRL_WIDTH, default 12, opaque control word width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- valid_D  in  1  instr_D holds a real instruction
- instr_D  in  32  instruction in decode
- pc_D  in  DATA_WIDTH  PC of instr_D
- ctrl_D  in  CTRL_WIDTH  control word from the control unit
- ImmSrc_D  in  3  immediate type: 0=I, 1=S, 2=B, 3=U, 4=J
- load_D  in  1  instr_D is a load
- uses_rs2_D  in  1  instr_D reads rs2
- flush_E  in  1  taken branch/jump resolved in EX
- RegWrite_W  in  1  writeback enable
- rd_W  in  ADDR_WIDTH  writeback address
- result_W  in  DATA_WIDTH  writeback data
- stall_D  out  1  hold fetch and instr_D this cycle
- valid_E  out  1  EX register holds a real instruction
- ctrl_E  out  CTRL_WIDTH  registered control word
- rd1_E, rd2_E  out  DATA_WIDTH  registered operands
- ImmExt_E  out  DATA_WIDTH  registered extended immediate
- pc_E  out  DATA_WIDTH  registered PC
- rs1_E, rs2_E, rd_E  out  ADDR_WIDTH  registered register addresses
- a0  out  DATA_WIDTH  live contents of register 10

Function
REQ-003 Fields SHALL be rs1=instr_D[19:15], rs2=instr_D[24:20], rd=instr_D[11:7], zero-extended or truncated to ADDR_WIDTH.
REQ-004 Register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational reads, one write on clk edge when RegWrite_W=1 and rd_W!=0.
REQ-005 Register 0 SHALL always read 0; writes to it are discarded.
REQ-006 Write-first bypass: if RegWrite_W=1, rd_W!=0 and rd_W equals a read address, that read returns result_W in the same cycle.
REQ-007 a0 SHALL show stored register 10 contents (not bypassed) and update the cycle after the write.
REQ-008 Immediate (sign-extended from instr_D[31]): I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; U={instr[31:12],12'b0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; ImmSrc 5-7 SHALL give 0.
REQ-009 Load-use hazard: stall_D=1 combinationally iff valid_D & valid_E & load_E & rd_E!=0 & (rs1==rd_E | (uses_rs2_D & rs2==rd_E)); load_E is an internal register tracking load_D.
REQ-010 Latency: decode results SHALL appear on *_E outputs one cycle after capture.
REQ-011 Each edge, ID/EX register update SHALL follow, highest priority first: rst -> clear; flush_E -> bubble; stall_D -> bubble; else capture valid_D and all decoded fields.
REQ-012 Bubble: valid_E=0, load_E=0, ctrl_E=0, rd_E=0; other _E fields don't-care, implemented as hold.
REQ-013 flush_E SHALL NOT suppress stall_D evaluation; the fetch unit owns flush/stall arbitration upstream.
REQ-014 With valid_D=0 and no flush/stall, valid_E SHALL be 0 next cycle, ctrl_E=0.
REQ-015 Register file writes SHALL proceed regardless of stall_D or flush_E.

Reset
REQ-016 While rst=1 at an edge: all registers and every ID/EX field SHALL clear to 0, so valid_E=0, a0=0, stall_D=0 the cycle after.
REQ-017 Reset mid-stall SHALL drop the stall: load_E clears, so stall_D=0 the following cycle.
REQ-018 Writeback during a rst cycle SHALL be discarded.

Verification
REQ-019 Scenarios:
- Write x5=0x0000_00AA, next cycle decode addi x6,x5,3 -> rd1_E=0xAA, ImmExt_E=3, valid_E=1.
- Same-cycle write x7=0x1234 while decoding add x8,x7,x7 -> rd1_E=rd2_E=0x1234.
- lw x9 in EX (valid_E=1,load_E=1), decode add x10,x9,x1 -> stall_D=1, next valid_E=0; then stall_D=0, capture.
- Write x0=0xFFFF_FFFF, decode using rs1=x0 -> rd1_E=0; B-type instr 0xFE000EE3 -> ImmExt_E=0xFFFF_FFFC.
- flush_E and stall_D both high -> valid_E=0, ctrl_E=0; write x10=0x55 -> a0=0x55 next cycle.
- rst asserted with lw in EX -> stall_D=0, valid_E=0, a0=0 after the edge.
